// File: rtl/cirno9_sram_arb.sv
// Two-master arbiter in front of the single-port sram32: m0 has fixed priority,
// m1 is forced through after STARVE_LIM consecutive denied cycles.
module cirno9_sram_arb #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            m0_req,
   input  logic [DW/8-1:0] m0_we,
   input  logic [AW-1:0]   m0_adr,
   input  logic [DW-1:0]   m0_wdat,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [DW-1:0]   m0_rdat,
   input  logic            m1_req,
   input  logic [DW/8-1:0] m1_we,
   input  logic [AW-1:0]   m1_adr,
   input  logic [DW-1:0]   m1_wdat,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdat,
   output logic            sram_en,
   output logic [DW/8-1:0] sram_we,
   output logic [AW-1:0]   sram_adr,
   output logic [DW-1:0]   sram_din,
   input  logic [DW-1:0]   sram_dout
);

   localparam int unsigned BW = DW / 8;
   localparam int unsigned CW = $clog2(STARVE_LIM + 1);

   logic [CW-1:0] starve_cnt;
   logic          force_m1;
   logic          rsp_rd;
   logic          rsp_owner;

   // Grant decision and SRAM request mux; idle bus is driven to all zeros.
   always_comb begin
      force_m1 = m1_req && (starve_cnt == CW'(STARVE_LIM));
      m1_gnt   = m1_req && (!m0_req || force_m1);
      m0_gnt   = m0_req && !m1_gnt;
      sram_en  = m0_gnt || m1_gnt;
      sram_we  = '0;
      sram_adr = '0;
      sram_din = '0;
      if (m1_gnt) begin
         sram_we  = m1_we;
         sram_adr = m1_adr;
         sram_din = m1_wdat;
      end else if (m0_gnt) begin
         sram_we  = m0_we;
         sram_adr = m0_adr;
         sram_din = m0_wdat;
      end
   end

   // Starvation counter and one-deep read response tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         rsp_rd     <= 1'b0;
         rsp_owner  <= 1'b0;
      end else begin
         if (m1_req && !m1_gnt) begin
            if (starve_cnt != CW'(STARVE_LIM))
               starve_cnt <= starve_cnt + CW'(1);
         end else begin
            starve_cnt <= '0;
         end
         rsp_rd    <= sram_en && (sram_we == BW'(0));
         rsp_owner <= m1_gnt;
      end
   end

   // Read data is shared; the matching rvalid qualifies it.
   assign m0_rvalid = rsp_rd && !rsp_owner;
   assign m1_rvalid = rsp_rd && rsp_owner;
   assign m0_rdat   = sram_dout;
   assign m1_rdat   = sram_dout;

endmodule

// File: tb/tb_cirno9_sram_arb.sv
// Bench for cirno9_sram_arb: SRAM behavioural model, reference arbiter model with
// read-response scoreboard, directed scenarios and a constrained-random phase.
module tb_cirno9_sram_arb;

   localparam int unsigned LIM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic [3:0]  m0_we = '0, m1_we = '0;
   logic [31:0] m0_adr = '0, m1_adr = '0, m0_wdat = '0, m1_wdat = '0;
   logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_en;
   logic [31:0] m0_rdat, m1_rdat, sram_adr, sram_din;
   logic [3:0]  sram_we;
   logic [31:0] sram_dout = '0;

   cirno9_sram_arb #(.AW(32), .DW(32), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdat(m0_wdat),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdat(m0_rdat),
      .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdat(m1_wdat),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdat(m1_rdat),
      .sram_en(sram_en), .sram_we(sram_we), .sram_adr(sram_adr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // sram32 stand-in: byte-lane writes, registered read data
   logic [31:0] mem [64];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we != 4'd0) begin
            for (int b = 0; b < 4; b++)
               if (sram_we[b]) mem[sram_adr[7:2]][8*b +: 8] = sram_din[8*b +: 8];
         end else begin
            sram_dout <= mem[sram_adr[7:2]];
         end
      end
   end

   // Reference model: who should own the bus, and what memory should hold
   typedef struct {
      logic        owner;
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t        q[$];
   logic [31:0] ref_mem [64];
   int          waited = 0;
   logic        exp_g0 = 1'b0, exp_g1 = 1'b0;

   always @(negedge clk) begin
      logic [3:0]  w;
      logic [31:0] a, d;
      if (rst) begin
         q.delete();
         waited = 0;
         exp_g0 = 1'b0;
         exp_g1 = 1'b0;
         chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      end else begin
         // m1 wins when m0 is absent or m1 has already been denied LIM cycles in a row
         exp_g1 = m1_req && (!m0_req || waited >= int'(LIM));
         exp_g0 = m0_req && !exp_g1;
         chk("starve_cnt", 32'(dut.starve_cnt), 32'(waited));
         chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, exp_g0});
         chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, exp_g1});
         chk("sram_en", {31'd0, sram_en}, {31'd0, exp_g0 | exp_g1});
         w = exp_g1 ? m1_we : exp_g0 ? m0_we : 4'd0;
         a = exp_g1 ? m1_adr : exp_g0 ? m0_adr : 32'd0;
         d = exp_g1 ? m1_wdat : exp_g0 ? m0_wdat : 32'd0;
         chk("sram_we", {28'd0, sram_we}, {28'd0, w});
         chk("sram_adr", sram_adr, a);
         chk("sram_din", sram_din, d);
         if (exp_g0 || exp_g1) begin
            if (w == 4'd0) begin
               q.push_back('{owner: exp_g1, data: ref_mem[a[7:2]], due: cyc + 1});
            end else begin
               for (int b = 0; b < 4; b++)
                  if (w[b]) ref_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
            end
         end
         waited = (m1_req && !exp_g1) ? waited + 1 : 0;
      end
   end

   // Monitor: every rvalid must match the oldest outstanding read
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (m0_rvalid || m1_rvalid) begin
            chk("rvalid_onehot", {31'd0, m0_rvalid & m1_rvalid}, 32'd0);
            if (q.size() == 0) begin
               chk("spurious_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            end else begin
               e = q.pop_front();
               chk("rsp_owner", {31'd0, m1_rvalid}, {31'd0, e.owner});
               chk("rsp_data", e.owner ? m1_rdat : m0_rdat, e.data);
               chk("rsp_latency", 32'(cyc), 32'(e.due));
            end
         end else if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("missing_rvalid", 32'd0, 32'd1);
         end
      end
   end

   task automatic set_in(input logic r0, input logic [3:0] w0, input logic [31:0] a0, d0,
                         input logic r1, input logic [3:0] w1, input logic [31:0] a1, d1);
      m0_req = r0; m0_we = w0; m0_adr = a0; m0_wdat = d0;
      m1_req = r1; m1_we = w1; m1_adr = a1; m1_wdat = d1;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      next();
   endtask

   logic        pr [2];
   logic [3:0]  pw [2];
   logic [31:0] pa [2], pd [2];

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[4]  = 32'hDEADBEEF; ref_mem[4]  = 32'hDEADBEEF;
      mem[8]  = 32'h0;        ref_mem[8]  = 32'h0;
      mem[12] = 32'h11112222; ref_mem[12] = 32'h11112222;
      mem[13] = 32'h33334444; ref_mem[13] = 32'h33334444;

      next();
      chk("rst_idle_en", {31'd0, sram_en}, 32'd0);
      next();
      rst = 1'b0;

      // m0 read of 0x10
      set_in(1, 0, 32'h10, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rd0_gnt", {31'd0, m0_gnt}, 32'd1);
      chk("rd0_adr", sram_adr, 32'h10);
      next();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rd0_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
      chk("rd0_rdat", m0_rdat, 32'hDEADBEEF);
      next();

      // m1 partial write then read-back
      set_in(0, 0, 0, 0, 1, 4'b0011, 32'h20, 32'hA5A5A5A5);
      @(negedge clk);
      chk("wr1_we", {28'd0, sram_we}, 32'h3);
      chk("wr1_din", sram_din, 32'hA5A5A5A5);
      next();
      set_in(0, 0, 0, 0, 1, 0, 32'h20, 0);
      @(negedge clk);
      chk("wr1_no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      next();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("rd1_rdat", m1_rvalid ? m1_rdat : 32'hFFFFFFFF, 32'h0000A5A5);
      next();

      // alternating owners, back-to-back
      set_in(1, 0, 32'h30, 0, 0, 0, 0, 0);
      next();
      set_in(0, 0, 0, 0, 1, 0, 32'h34, 0);
      @(negedge clk);
      chk("alt_m0_rdat", m0_rvalid ? m0_rdat : 32'hFFFFFFFF, 32'h11112222);
      next();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("alt_m1_rdat", m1_rvalid ? m1_rdat : 32'hFFFFFFFF, 32'h33334444);
      next();

      // continuous contention: m0 x4, m1 x1, repeating
      for (int k = 0; k < 15; k++) begin
         set_in(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
         @(negedge clk);
         chk("seq_m1_gnt", {31'd0, m1_gnt}, {31'd0, (k % 5) == 4});
         chk("seq_cnt", 32'(dut.starve_cnt), 32'(k % 5));
         next();
      end
      idle();

      // reset in the cycle after a read grant drops the response
      set_in(1, 0, 32'h10, 0, 0, 0, 0, 0);
      next();
      rst = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_mid_rvalid", {31'd0, m0_rvalid}, 32'd0);
      chk("rst_mid_cnt", 32'(dut.starve_cnt), 32'd0);
      next();
      rst = 1'b0;
      set_in(1, 0, 32'h10, 0, 0, 0, 0, 0);
      next();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("post_rst_rdat", m0_rvalid ? m0_rdat : 32'hFFFFFFFF, 32'hDEADBEEF);
      next();

      // m1 withdraws at count 3, then waits the full limit again
      for (int k = 0; k < 3; k++) begin
         set_in(1, 0, 32'h48, 0, 1, 0, 32'h4C, 0);
         next();
      end
      set_in(1, 0, 32'h48, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("drop_cnt3", 32'(dut.starve_cnt), 32'd3);
      next();
      for (int k = 0; k < 5; k++) begin
         set_in(1, 0, 32'h48, 0, 1, 0, 32'h4C, 0);
         @(negedge clk);
         chk("rewait_m1_gnt", {31'd0, m1_gnt}, {31'd0, k == 4});
         next();
      end
      idle();

      // random traffic from well-behaved masters that hold until granted
      for (int m = 0; m < 2; m++) pr[m] = 1'b0;
      for (int n = 0; n < 500; n++) begin
         if (pr[0] && exp_g0) pr[0] = 1'b0;
         if (pr[1] && exp_g1) pr[1] = 1'b0;
         for (int m = 0; m < 2; m++) begin
            if (!pr[m] && ($urandom % 4) != 0) begin
               pr[m] = 1'b1;
               pw[m] = ($urandom % 2) ? 4'(($urandom)) : 4'd0;
               pa[m] = 32'($urandom_range(0, 63)) << 2;
               pd[m] = $urandom;
            end
         end
         set_in(pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1]);
         next();
      end
      for (int n = 0; n < 3; n++) idle();
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
